// File: rtl/mips_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states
// and iteration count.
package mips_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int MULDIV_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  function automatic logic [31:0] abs_if_signed(input logic [31:0] value, input logic is_signed);
    return (is_signed && value[31]) ? -value : value;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the unsigned multiply (shift-add) or restoring divide
// (shift-subtract) on a shared 64-bit accumulator. Divider exists only with MULDIV_DIV_EN.
module muldiv_core (
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  output logic [63:0] acc_next
);

  // Multiply: acc = {partial product, remaining multiplier bits}.
  logic [32:0] sum;
  logic [63:0] mul_next;

  assign sum      = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? operand : 32'd0)};
  assign mul_next = {sum, acc[31:1]};

`ifdef MULDIV_DIV_EN
  // Divide: acc = {remainder, dividend bits being shifted out / quotient bits in}.
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        fits;
  logic [63:0] div_next;

  assign shifted  = acc[63:31];
  assign fits     = shifted >= {1'b0, operand};
  assign diff     = shifted[31:0] - operand;
  assign div_next = fits ? {diff, acc[30:0], 1'b1} : {shifted[31:0], acc[30:0], 1'b0};
  assign acc_next = is_div ? div_next : mul_next;
`else
  assign acc_next = is_div ? acc : mul_next;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; 32 iterations plus a sign-fix cycle.
// Define MULDIV_DIV_EN to include the divider; otherwise DIV/DIVU complete immediately.
module muldiv_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  muldiv_state_t state_reg, state_next;

  logic [63:0] acc_reg;
  logic [63:0] acc_step;
  logic [31:0] operand_reg;
  logic [5:0]  cnt_reg;
  logic        is_div_reg;
  logic        neg_res_reg;
  logic        neg_rem_reg;
  logic        div_zero_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        busy_reg;
  logic        done_reg;

  logic        op_div;
  logic        op_signed;
  logic        launch;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [63:0] prod_fixed;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;

  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign launch    = (state_reg == IDLE) && start && !flush;
  assign abs1      = abs_if_signed(data1, op_signed);
  assign abs2      = abs_if_signed(data2, op_signed);

  muldiv_core u_core (
    .is_div   (is_div_reg),
    .acc      (acc_reg),
    .operand  (operand_reg),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (launch) begin
`ifdef MULDIV_DIV_EN
          state_next = RUN;
`else
          state_next = op_div ? DONE : RUN;
`endif
        end
      end
      RUN: begin
        if (flush) begin
          state_next = IDLE;
        end else if (cnt_reg == 6'd1) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = flush ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Divide-by-zero leaves remainder = |dividend|, so only the quotient needs forcing.
  assign prod_fixed = neg_res_reg ? -acc_reg : acc_reg;
  assign quo_fixed  = div_zero_reg ? 32'hFFFF_FFFF :
                      (neg_res_reg ? -acc_reg[31:0] : acc_reg[31:0]);
  assign rem_fixed  = neg_rem_reg ? -acc_reg[63:32] : acc_reg[63:32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg      <= '0;
      operand_reg  <= '0;
      cnt_reg      <= '0;
      is_div_reg   <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      busy_reg <= (state_next != IDLE);
      done_reg <= (state_next == DONE);
      case (state_reg)
        IDLE: begin
          if (launch) begin
            is_div_reg   <= op_div;
            neg_res_reg  <= op_signed && (data1[31] ^ data2[31]);
            neg_rem_reg  <= op_signed && data1[31];
            div_zero_reg <= op_div && (data2 == 32'd0);
            cnt_reg      <= 6'(MULDIV_ITER);
            if (op_div) begin
              acc_reg     <= {32'd0, abs1};
              operand_reg <= abs2;
            end else begin
              acc_reg     <= {32'd0, abs2};
              operand_reg <= abs1;
            end
          end
        end
        RUN: begin
          acc_reg <= acc_step;
          cnt_reg <= cnt_reg - 6'd1;
        end
        FIX: begin
          if (!flush) begin
            if (is_div_reg) begin
              hi_reg <= rem_fixed;
              lo_reg <= quo_fixed;
            end else begin
              hi_reg <= prod_fixed[63:32];
              lo_reg <= prod_fixed[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
